// File: rtl/qam_pkg.sv
// Shared 16-QAM definitions: controller state encoding and the Gray-to-level map
// that the demapper's inverse slicer also uses.
package qam_pkg;

  localparam int BITS_PER_SYM = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    SEND = 2'b10,
    DONE = 2'b11
  } state_t;

  // Gray-coded 2-bit field to signed amplitude: 00->-3, 01->-1, 11->+1, 10->+3
  function automatic logic signed [2:0] map_gray2(input logic [1:0] bits);
    case (bits)
      2'b00:   map_gray2 = -3'sd3;
      2'b01:   map_gray2 = -3'sd1;
      2'b11:   map_gray2 = 3'sd1;
      default: map_gray2 = 3'sd3;
    endcase
  endfunction

endpackage

// File: rtl/qam_mapper_controller_if.sv
// Host-side bundle of the QAM mapper controller: write/start controls, status flags
// and the mapped symbol stream toward the modulator.
interface qam_mapper_controller_if #(parameter int DEPTH = 16);
  import qam_pkg::*;

  logic                      enable;
  logic                      wr_en;
  logic [BITS_PER_SYM-1:0]   wr_data;
  logic                      start;
  logic                      full;
  logic                      available;
  logic                      busy;
  logic                      complete;
  logic [$clog2(DEPTH):0]    fill_level;
  logic                      sym_valid;
  logic signed [2:0]         i_out;
  logic signed [2:0]         q_out;

  modport master (
    output enable, wr_en, wr_data, start,
    input  full, available, busy, complete, fill_level, sym_valid, i_out, q_out
  );

  modport slave (
    input  enable, wr_en, wr_data, start,
    output full, available, busy, complete, fill_level, sym_valid, i_out, q_out
  );

endinterface

// File: rtl/qam_tx_fifo.sv
// Synchronous word FIFO with synchronous flush; pointers carry one extra wrap bit
// so full and empty are distinguished without a separate counter.
module qam_tx_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_wr_en,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_rd_en,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_wr;
  logic             w_do_rd;

  assign o_full    = (r_wptr ^ r_rptr) == (AW+1)'(DEPTH);
  assign o_empty   = r_wptr == r_rptr;
  assign o_level   = r_wptr - r_rptr;
  assign o_rd_data = r_mem[r_rptr[AW-1:0]];
  assign w_do_wr   = i_wr_en && !o_full && !i_flush;
  assign w_do_rd   = i_rd_en && !o_empty && !i_flush;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + 1'b1;
      if (w_do_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_wr) r_mem[r_wptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/qam_mapper_controller.sv
// Buffers a host burst of 4-bit words and emits one Gray-mapped 16-QAM I/Q pair
// every SYM_DIV clocks once started.
module qam_mapper_controller
  import qam_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int SYM_DIV = 4
) (
  input  logic dclk,
  input  logic reset,
  qam_mapper_controller_if.slave bus
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int CNT_W = $clog2(SYM_DIV);

  state_t                  r_state;
  state_t                  w_next;
  logic                    w_wr;
  logic                    w_rd;
  logic                    w_flush;
  logic                    w_full;
  logic                    w_empty;
  logic [LVL_W-1:0]        w_level;
  logic [BITS_PER_SYM-1:0] w_rd_data;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_sym_valid;
  logic signed [2:0]       r_i;
  logic signed [2:0]       r_q;

  qam_tx_fifo #(.WIDTH(BITS_PER_SYM), .DEPTH(DEPTH)) u_fifo (
    .i_clk     (dclk),
    .i_rst     (reset),
    .i_flush   (w_flush),
    .i_wr_en   (w_wr),
    .i_wr_data (bus.wr_data),
    .i_rd_en   (w_rd),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (w_level)
  );

  always_ff @(posedge dclk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_wr    = 1'b0;
    w_rd    = 1'b0;
    w_flush = 1'b0;
    if (!bus.enable) begin
      w_next  = IDLE;
      w_flush = 1'b1;
    end else begin
      case (r_state)
        IDLE: if (bus.wr_en && !w_full) begin
          w_wr   = 1'b1;
          w_next = FILL;
        end
        // FIFO is never empty in FILL, so start alone launches the burst
        FILL: begin
          w_wr = bus.wr_en && !w_full;
          if (bus.start) w_next = SEND;
        end
        SEND: if (r_cnt == '0) begin
          if (!w_empty) w_rd   = 1'b1;
          else          w_next = DONE;
        end
        DONE: if (!bus.start) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge dclk or posedge reset) begin
    if (reset)                               r_cnt <= '0;
    else if (r_state != SEND)                r_cnt <= '0;
    else if (r_cnt == CNT_W'(SYM_DIV - 1))   r_cnt <= '0;
    else                                     r_cnt <= r_cnt + 1'b1;
  end

  // I/Q hold their last value between pulses and through DONE
  always_ff @(posedge dclk or posedge reset) begin
    if (reset) begin
      r_sym_valid <= 1'b0;
      r_i         <= '0;
      r_q         <= '0;
    end else begin
      r_sym_valid <= w_rd;
      if (w_rd) begin
        r_i <= map_gray2(w_rd_data[3:2]);
        r_q <= map_gray2(w_rd_data[1:0]);
      end
    end
  end

  assign bus.available  = (r_state == IDLE || r_state == FILL) && !w_full;
  assign bus.full       = !bus.available;
  assign bus.busy       = r_state == SEND;
  assign bus.complete   = r_state == DONE;
  assign bus.fill_level = w_level;
  assign bus.sym_valid  = r_sym_valid;
  assign bus.i_out      = r_i;
  assign bus.q_out      = r_q;

endmodule
